dna_reader: RTL

- Parametrised device-DNA readout engine and the next generation of the single-shot DNA wrapper.
- Runs the DNA primitive through LOAD and SHIFT and assembles a DNA_WIDTH-bit identifier, with a configurable settle delay and shift-rate divider.
- Supports on-demand re-read, auto-read after reset, and an optional double-read consistency check.
- Feeds housekeeping/ID registers; dna_o is static whenever valid_o=1.

---
 rtl/dna_reader_pkg.sv | 31 +++
 rtl/dna_prim_wrap.sv | 36 +++
 rtl/dna_reader.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/dna_reader_pkg.sv
// Shared types and sizing helpers for the device-DNA readout engine.
// The state encoding is fixed at 3 bits so checkers can bind to it directly.
package dna_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SETTLE  = 3'd1,
    ST_LOAD    = 3'd2,
    ST_SHIFT   = 3'd3,
    ST_COMPARE = 3'd4,
    ST_DONE    = 3'd5
  } state_e;

  // Width of a counter that runs 0..n-1; never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int settle_cnt_w(input int settle_cycles);
    return cnt_w(settle_cycles);
  endfunction

  function automatic int div_cnt_w(input int shift_div);
    return cnt_w(shift_div);
  endfunction

  function automatic int bit_cnt_w(input int dna_width);
    return cnt_w(dna_width);
  endfunction

endpackage

// File: rtl/dna_prim_wrap.sv
// Device-DNA port stand-in: FAMILY picks the primitive depth (DNA_PORTE2 = 96 bits,
// DNA_PORT = 57 bits). READ parallel-loads SIM_DNA, SHIFT moves toward bit 0, DOUT = bit 0.
module dna_prim_wrap #(
  parameter int                   DNA_WIDTH = 96,
  parameter logic [DNA_WIDTH-1:0] SIM_DNA   = '0,
  parameter string                FAMILY    = "ULTRASCALE"
) (
  input  logic clk,
  input  logic din,
  input  logic read,
  input  logic shift,
  output logic dout
);

  localparam int PRIM_W = (FAMILY == "7SERIES") ? 57 : 96;

  logic [PRIM_W-1:0] prim_q;
  logic [PRIM_W-1:0] prim_d;

  always_comb begin
    prim_d = prim_q;
    if (read) begin
      prim_d = PRIM_W'(SIM_DNA);
    end else if (shift) begin
      prim_d = {din, prim_q[PRIM_W-1:1]};
    end
  end

  // The silicon primitive has no reset; contents are defined only after READ.
  always_ff @(posedge clk) begin
    prim_q <= prim_d;
  end

  assign dout = prim_q[0];

endmodule

// File: rtl/dna_reader.sv
// Device-DNA readout engine: settle, LOAD, SHIFT DNA_WIDTH bits (LSB first) into an
// identifier register, with optional double-read consistency check.
module dna_reader
  import dna_reader_pkg::*;
#(
  parameter int                   DNA_WIDTH     = 96,
  parameter logic [DNA_WIDTH-1:0] SIM_DNA       = {96{1'b0}},
  parameter int                   SETTLE_CYCLES = 96,
  parameter int                   SHIFT_DIV     = 1,
  parameter int                   AUTO_START    = 1,
  parameter int                   CHECK_EN      = 0,
  parameter string                FAMILY        = "ULTRASCALE"
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  output logic                 busy_o,
  output logic                 valid_o,
  output logic [DNA_WIDTH-1:0] dna_o,
  output logic                 mismatch_o
);

  localparam int SW = settle_cnt_w(SETTLE_CYCLES);
  localparam int DW = div_cnt_w(SHIFT_DIV);
  localparam int BW = bit_cnt_w(DNA_WIDTH);

  localparam logic [SW-1:0] SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [DW-1:0] DIV_LAST    = DW'(SHIFT_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST    = BW'(DNA_WIDTH - 1);

  // Handshake: start_i is a one-cycle request sampled only in IDLE/DONE; while
  // busy_o=1 it is dropped. valid_o=1 means dna_o/mismatch_o are final and stable.

  state_e                 state_q, state_d;
  logic [SW-1:0]          settle_cnt_q, settle_cnt_d;
  logic [DW-1:0]          div_cnt_q, div_cnt_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic                   pass_q, pass_d;
  logic                   auto_q, auto_d;
  logic [DNA_WIDTH-1:0]   shreg_q, shreg_d;
  logic [DNA_WIDTH-1:0]   pass1_q, pass1_d;
  logic [DNA_WIDTH-1:0]   dna_q, dna_d;
  logic                   busy_q, busy_d;
  logic                   valid_q, valid_d;
  logic                   mismatch_q, mismatch_d;

  logic prim_din;
  logic prim_read;
  logic prim_shift;
  logic prim_dout;
  logic launch;

  assign launch = ((state_q == ST_IDLE) && (start_i || auto_q)) ||
                  ((state_q == ST_DONE) && start_i);

  always_comb begin
    state_d      = state_q;
    settle_cnt_d = settle_cnt_q;
    div_cnt_d    = div_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    pass_d       = pass_q;
    auto_d       = auto_q;
    shreg_d      = shreg_q;
    pass1_d      = pass1_q;
    dna_d        = dna_q;
    busy_d       = busy_q;
    valid_d      = valid_q;
    mismatch_d   = mismatch_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (launch) begin
          auto_d       = 1'b0;
          valid_d      = 1'b0;
          mismatch_d   = 1'b0;
          busy_d       = 1'b1;
          settle_cnt_d = '0;
          pass_d       = 1'b0;
          // A zero settle time skips SETTLE entirely so LOAD follows immediately.
          state_d      = (SETTLE_CYCLES == 0) ? ST_LOAD : ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        if (settle_cnt_q == SETTLE_LAST) begin
          state_d = ST_LOAD;
        end else begin
          settle_cnt_d = settle_cnt_q + SW'(1);
        end
      end
      ST_LOAD: begin
        bit_cnt_d = '0;
        div_cnt_d = '0;
        shreg_d   = '0;
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_cnt_q == DIV_LAST) begin
          div_cnt_d          = '0;
          shreg_d[bit_cnt_q] = prim_dout;
          if (bit_cnt_q == BIT_LAST) begin
            if ((CHECK_EN != 0) && !pass_q) begin
              pass1_d = shreg_d;
              pass_d  = 1'b1;
              state_d = ST_LOAD;
            end else begin
              state_d = ST_COMPARE;
            end
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          div_cnt_d = div_cnt_q + DW'(1);
        end
      end
      ST_COMPARE: begin
        dna_d      = shreg_q;
        mismatch_d = (CHECK_EN != 0) && (shreg_q != pass1_q);
        valid_d    = 1'b1;
        busy_d     = 1'b0;
        state_d    = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      settle_cnt_q <= '0;
      div_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      pass_q       <= 1'b0;
      auto_q       <= (AUTO_START != 0);
      shreg_q      <= '0;
      pass1_q      <= '0;
      dna_q        <= '0;
      busy_q       <= 1'b0;
      valid_q      <= 1'b0;
      mismatch_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_cnt_q <= settle_cnt_d;
      div_cnt_q    <= div_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      pass_q       <= pass_d;
      auto_q       <= auto_d;
      shreg_q      <= shreg_d;
      pass1_q      <= pass1_d;
      dna_q        <= dna_d;
      busy_q       <= busy_d;
      valid_q      <= valid_d;
      mismatch_q   <= mismatch_d;
    end
  end

  // Primitive strobes decode straight from state so SHIFT lines up with the sample.
  assign prim_din   = 1'b0;
  assign prim_read  = (state_q == ST_LOAD);
  assign prim_shift = (state_q == ST_SHIFT) && (div_cnt_q == DIV_LAST);

  dna_prim_wrap #(
    .DNA_WIDTH (DNA_WIDTH),
    .SIM_DNA   (SIM_DNA),
    .FAMILY    (FAMILY)
  ) u_prim (
    .clk   (clk),
    .din   (prim_din),
    .read  (prim_read),
    .shift (prim_shift),
    .dout  (prim_dout)
  );

  assign busy_o     = busy_q;
  assign valid_o    = valid_q;
  assign dna_o      = dna_q;
  assign mismatch_o = mismatch_q;

endmodule
